// File: rtl/alu_if.sv
// Operand/opcode bus and result/status outputs of the ALU, with
// master (driver) and slave (ALU) views.
interface alu_if #(
    parameter int W = 16
);
    logic [4:0]   alu_op;
    logic [W-1:0] operandA;
    logic [W-1:0] operandB;
    logic [W-1:0] resultAccumulator;
    logic [3:0]   flags;
    logic [W-1:0] result_q;
    logic [3:0]   flags_q;

    modport master (
        output alu_op, operandA, operandB,
        input  resultAccumulator, flags, result_q, flags_q
    );

    modport slave (
        input  alu_op, operandA, operandB,
        output resultAccumulator, flags, result_q, flags_q
    );
endinterface

// File: rtl/alu.sv
// W-bit signed ALU: combinational result/flags {Z,N,C,V} plus a
// registered accumulator/status copy with asynchronous clear.
module alu #(
    parameter int W = 16
) (
    input  logic clk,
    input  logic rst,
    alu_if.slave bus
);
    localparam int SW = $clog2(W);

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,
        OP_SUB   = 5'd1,
        OP_LSR   = 5'd2,
        OP_LSL   = 5'd3,
        OP_ASR   = 5'd4,
        OP_AND   = 5'd5,
        OP_OR    = 5'd6,
        OP_XOR   = 5'd7,
        OP_NOT   = 5'd8,
        OP_MUL   = 5'd9,
        OP_DIV   = 5'd10,
        OP_MOD   = 5'd11,
        OP_INC   = 5'd12,
        OP_DEC   = 5'd13,
        OP_CMP   = 5'd14,
        OP_PASSB = 5'd15
    } alu_opcode_e;

    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    alu_opcode_e         op;
    logic [W-1:0]        a;
    logic [W-1:0]        b;
    logic [SW-1:0]       s;
    logic [SW-1:0]       lsl_idx;
    logic [W-1:0]        add_b;
    logic                add_cin;
    logic [W:0]          sum;
    logic                add_v;
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    logic signed [W-1:0] div_b;
    logic signed [W-1:0] quot;
    logic signed [W-1:0] rem;
    logic signed [2*W-1:0] prod;
    logic                div_zero;
    logic                div_ovf;
    logic [W-1:0]        result_d;
    logic [W-1:0]        flag_res;
    logic                c_flag;
    logic                v_flag;
    logic [3:0]          flags_d;
    logic [W-1:0]        result_q;
    logic [3:0]          flags_q;

    // Shared adder: SUB/CMP/DEC feed A + ~B + 1 so carry means "no borrow".
    always_comb begin
        op      = alu_opcode_e'(bus.alu_op);
        a       = bus.operandA;
        b       = bus.operandB;
        add_b   = b;
        add_cin = 1'b0;
        case (op)
            OP_SUB, OP_CMP: begin
                add_b   = ~b;
                add_cin = 1'b1;
            end
            OP_INC: begin
                add_b   = W'(1);
                add_cin = 1'b0;
            end
            OP_DEC: begin
                add_b   = ~W'(1);
                add_cin = 1'b1;
            end
            default: begin
                add_b   = b;
                add_cin = 1'b0;
            end
        endcase
        sum   = {1'b0, a} + {1'b0, add_b} + (W+1)'(add_cin);
        add_v = (a[W-1] == add_b[W-1]) && (sum[W-1] != a[W-1]);
    end

    // Divisor is forced to 1 on the two trapping cases so the divider
    // never sees a zero divisor or the most-negative/-1 overflow.
    always_comb begin
        sa       = signed'(bus.operandA);
        sb       = signed'(bus.operandB);
        div_zero = (bus.operandB == '0);
        div_ovf  = (bus.operandA == MOST_NEG) && (bus.operandB == '1);
        div_b    = (div_zero || div_ovf) ? W'(signed'(1)) : sb;
        quot     = sa / div_b;
        rem      = sa % div_b;
        prod     = (2*W)'(sa) * (2*W)'(sb);
    end

    always_comb begin
        s        = b[SW-1:0];
        lsl_idx  = '0 - s;
        result_d = '0;
        flag_res = '0;
        c_flag   = 1'b0;
        v_flag   = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
                result_d = sum[W-1:0];
                c_flag   = sum[W];
                v_flag   = add_v;
            end
            OP_CMP: begin
                result_d = a;
                c_flag   = sum[W];
                v_flag   = add_v;
            end
            OP_LSR: begin
                result_d = a >> s;
                c_flag   = (s != '0) ? a[s - 1'b1] : 1'b0;
            end
            OP_LSL: begin
                result_d = a << s;
                c_flag   = (s != '0) ? a[lsl_idx] : 1'b0;
            end
            OP_ASR: begin
                result_d = W'(sa >>> s);
                c_flag   = (s != '0) ? a[s - 1'b1] : 1'b0;
            end
            OP_AND:   result_d = a & b;
            OP_OR:    result_d = a | b;
            OP_XOR:   result_d = a ^ b;
            OP_NOT:   result_d = ~a;
            OP_MUL: begin
                result_d = prod[W-1:0];
                v_flag   = (prod[2*W-1:W] != {W{prod[W-1]}});
            end
            OP_DIV: begin
                if (div_zero) begin
                    result_d = '0;
                    v_flag   = 1'b1;
                end else if (div_ovf) begin
                    result_d = MOST_NEG;
                    v_flag   = 1'b1;
                end else begin
                    result_d = quot;
                end
            end
            OP_MOD: begin
                if (div_zero) begin
                    result_d = '0;
                    v_flag   = 1'b1;
                end else if (div_ovf) begin
                    result_d = '0;
                end else begin
                    result_d = rem;
                end
            end
            OP_PASSB: result_d = b;
            default:  result_d = '0;
        endcase
        // Z/N follow the difference for CMP rather than the passed-through A.
        flag_res = (op == OP_CMP) ? sum[W-1:0] : result_d;
        flags_d  = {(flag_res == '0), flag_res[W-1], c_flag, v_flag};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign bus.resultAccumulator = result_d;
    assign bus.flags             = flags_d;
    assign bus.result_q          = result_q;
    assign bus.flags_q           = flags_q;
endmodule

// File: tb/tb_alu.sv
// Self-checking bench for the 16-bit ALU: directed edge cases, register
// behaviour around asynchronous reset, and random ops against a model.
module tb_alu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;

    alu_if #(.W(16)) bus ();

    alu #(.W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: {result[15:0], flags[3:0]} from plain integer arithmetic.
    function automatic logic [19:0] model(input logic [4:0] op, input logic [15:0] ua16,
                                          input logic [15:0] ub16);
        int ua, ub, a, b, s, full, r;
        logic c, v;
        logic [15:0] zr;
        ua = {16'h0, ua16};
        ub = {16'h0, ub16};
        a  = int'($signed(ua16));
        b  = int'($signed(ub16));
        s  = ub & 15;
        r  = 0;
        c  = 1'b0;
        v  = 1'b0;
        zr = 16'h0;
        case (op)
            5'd0: begin full = a + b; r = full; c = (ua + ub) > 65535; v = (full > 32767) || (full < -32768); end
            5'd1, 5'd14: begin full = a - b; r = full; c = (ua >= ub); v = (full > 32767) || (full < -32768); end
            5'd2: begin r = ua >> s; c = (s != 0) ? ((ua >> (s - 1)) & 1) != 0 : 1'b0; end
            5'd3: begin r = ua << s; c = (s != 0) ? ((ua >> (16 - s)) & 1) != 0 : 1'b0; end
            5'd4: begin r = a >>> s; c = (s != 0) ? ((ua >> (s - 1)) & 1) != 0 : 1'b0; end
            5'd5: r = ua & ub;
            5'd6: r = ua | ub;
            5'd7: r = ua ^ ub;
            5'd8: r = ~ua;
            5'd9: begin full = a * b; r = full; v = (full > 32767) || (full < -32768); end
            5'd10: begin
                if (b == 0) begin r = 0; v = 1'b1; end
                else if (a == -32768 && b == -1) begin r = -32768; v = 1'b1; end
                else r = a / b;
            end
            5'd11: begin
                if (b == 0) begin r = 0; v = 1'b1; end
                else r = a % b;
            end
            5'd12: begin full = a + 1; r = full; c = (ua + 1) > 65535; v = (full > 32767); end
            5'd13: begin full = a - 1; r = full; c = (ua >= 1); v = (full < -32768); end
            5'd15: r = ub;
            default: r = 0;
        endcase
        zr = r[15:0];
        if (op == 5'd14) return {a[15:0], (zr == 16'h0), zr[15], c, v};
        return {zr, (zr == 16'h0), zr[15], c, v};
    endfunction

    task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.alu_op   = op;
        bus.operandA = a;
        bus.operandB = b;
        #1;
    endtask

    task automatic directed(input string tag, input logic [4:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic [15:0] er, input logic [3:0] ef);
        drive(op, a, b);
        check(tag, {bus.resultAccumulator, bus.flags}, {er, ef});
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'h0000;
            3: return 16'hFFFF;
            4: return 16'(($urandom_range(0, 40)) - 20);
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic [4:0]  op;
        logic [15:0] ra, rb;
        drive(5'd0, 16'd2, 16'd3);
        check("reset_state", {bus.result_q, bus.flags_q}, 20'h0);

        directed("lsr_16_4",    5'd2,  16'd16,   16'd4,    16'd1,    4'b0000);
        directed("lsr_neg",     5'd2,  16'hFFF3, 16'hFFFD, 16'd7,    4'b0010);
        directed("lsr_9_1",     5'd2,  16'd9,    16'd1,    16'd4,    4'b0010);
        directed("lsr_s0",      5'd2,  16'd5,    16'd16,   16'd5,    4'b0000);
        directed("add_ovf",     5'd0,  16'h7FFF, 16'd1,    16'h8000, 4'b0101);
        directed("sub_zero",    5'd1,  16'd5,    16'd5,    16'd0,    4'b1010);
        directed("cmp_3_7",     5'd14, 16'd3,    16'd7,    16'd3,    4'b0100);
        directed("div_by_0",    5'd10, 16'd7,    16'd0,    16'd0,    4'b1001);
        directed("div_min_m1",  5'd10, 16'h8000, 16'hFFFF, 16'h8000, 4'b0101);
        directed("mul_300sq",   5'd9,  16'd300,  16'd300,  16'h5F90, 4'b0001);
        directed("mod_m7_3",    5'd11, 16'hFFF9, 16'd3,    16'hFFFF, 4'b0100);
        directed("lsl_carry",   5'd3,  16'h4001, 16'd2,    16'h0004, 4'b0010);
        directed("asr_neg",     5'd4,  16'h8001, 16'd1,    16'hC000, 4'b0110);
        directed("inc_wrap",    5'd12, 16'hFFFF, 16'd9,    16'h0000, 4'b1010);
        directed("dec_min",     5'd13, 16'h8000, 16'd9,    16'h7FFF, 4'b0011);
        directed("reserved",    5'd21, 16'h1234, 16'h5678, 16'h0000, 4'b1000);

        // Register behaviour around an asynchronous reset pulse.
        @(negedge clk);
        rst = 1'b0;
        drive(5'd0, 16'd2, 16'd3);
        @(posedge clk);
        #1;
        check("reg_load", {bus.result_q, bus.flags_q}, {16'd5, 4'b0000});
        #1 rst = 1'b1;
        #1;
        check("reg_async_clr", {bus.result_q, bus.flags_q}, 20'h0);
        check("comb_during_rst", {bus.resultAccumulator, bus.flags}, {16'd5, 4'b0000});
        #1 rst = 1'b0;
        #1;
        check("reg_hold_after_rst", {bus.result_q, bus.flags_q}, 20'h0);
        @(posedge clk);
        #1;
        check("reg_reload", {bus.result_q, bus.flags_q}, {16'd5, 4'b0000});

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            op = 5'($urandom_range(0, 31));
            ra = pick();
            rb = pick();
            drive(op, ra, rb);
            check($sformatf("rand_comb op=%0d a=%h b=%h", op, ra, rb),
                  {bus.resultAccumulator, bus.flags}, model(op, ra, rb));
            @(posedge clk);
            #1;
            check($sformatf("rand_reg op=%0d a=%h b=%h", op, ra, rb),
                  {bus.result_q, bus.flags_q}, model(op, ra, rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
